line_arbiter: RTL and testbench
===============================

// Module: line_arbiter
// PURPOSE
//  Parametrised N-channel arbiter between cache-line miss/writeback ports and the
//  single 256-bit physical memory port. It replaces the fixed two-port I/D hookup
//  between cache_hierarchy and pmem. One line transaction is in flight at a time.
//  Grant policy is round-robin or fixed priority.
// PARAMETERS
//  NUM_CH   2    number of requesting channels (>=1)
//  LINE_W   256  cache line width in bits
//  ADDR_W   32   byte address width
//  RR_MODE  1    1: round-robin grant; 0: fixed priority, lowest index wins
// PORTS
//  clk         in   1               system clock
//  rst         in   1               asynchronous, active-high reset
//  ch_read     in   NUM_CH          per-channel line read request, held until ch_resp
//  ch_write    in   NUM_CH          per-channel line write request, held until ch_resp
//  ch_address  in   NUM_CH*ADDR_W   per-channel line address (packed, ch0 in LSBs)
//  ch_wdata    in   NUM_CH*LINE_W   per-channel write line
//  ch_rdata    out  LINE_W          read line, broadcast to all channels
//  ch_resp     out  NUM_CH          one-hot completion pulse to the granted channel
//  pmem_read   out  1               physical memory read
//  pmem_write  out  1               physical memory write
//  pmem_address out ADDR_W          physical memory address
//  pmem_wdata  out  LINE_W          physical memory write data
//  pmem_rdata  in   LINE_W          physical memory read data
//  pmem_resp   in   1               physical memory completion
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant=0, captured addr/wdata/op=0. All outputs 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: req[i] = ch_read[i]|ch_write[i]. If any req is set, pick winner w and
//         capture w, ch_address[w], ch_wdata[w], op=ch_write[w]?WR:RD. Go to BUSY.
//   BUSY: pmem_read=(op==RD), pmem_write=(op==WR). pmem_address and pmem_wdata
//         come from the captured regs, stable for the whole transaction.
//         On pmem_resp, ch_resp[grant]=1 in the same cycle and ch_rdata=pmem_rdata
//         (combinational). Go to DONE.
//   DONE: one idle cycle with no pmem strobe and no grant, so the requester can drop
//         its request. Go to IDLE.
//  Latency: request seen in IDLE at edge t -> pmem strobe in cycle t+1.
//   Best case with pmem_resp in the first BUSY cycle: 3 cycles request-to-request.
//  Round-robin: search starts at rr_ptr and wraps modulo NUM_CH. On grant,
//   rr_ptr <= (w+1) mod NUM_CH, so NUM_CH-1 wraps to 0. In fixed mode rr_ptr is unused.
//  ch_resp is 0 outside BUSY&pmem_resp. ch_rdata = pmem_rdata at all times, valid only
//   with ch_resp.
//  Boundaries:
//   - read and write both set on one channel: write wins (writeback before fill).
//   - requester drops request mid-BUSY: transaction completes, ch_resp still pulses.
//   - requests arriving during BUSY/DONE: held, considered at next IDLE.
//   - NUM_CH=1: degenerates to a registered pass-through with the same FSM.
//   - rst mid-BUSY: strobes drop immediately (async); pmem transaction abandoned.
//  Widths: grant and rr_ptr are $clog2(NUM_CH) bits, minimum 1.
// STRUCTURE
//  Package line_arbiter_pkg: arb_state_t enum {IDLE,BUSY,DONE}; mem_op_t enum {RD,WR}.
//  Sub-module rr_picker: combinational, NUM_CH-wide request vector plus start pointer
//   in, winner index and valid out. Fixed priority = rr_picker with start forced to 0.
//  Top: one always_ff with async rst for state, captured regs and rr_ptr.
//   One always_comb for outputs.
// TESTING
//  1 Single read: ch1 read, addr=0x0000_1040, pmem_resp in 4th BUSY cycle, rdata=0xA5..A5
//    -> pmem_read high 4 cycles at 0x1040, ch_resp=2'b10 with ch_rdata=0xA5..A5, then DONE.
//  2 Collision, RR_MODE=1: ch0 and ch1 read continuously
//    -> grants alternate 0,1,0,1; each ch_resp is one-hot to the granted channel.
//  3 Collision, RR_MODE=0, NUM_CH=4: ch1 and ch3 read continuously
//    -> ch1 granted every time, ch3 never granted while ch1 requests.
//  4 ch0 asserts read and write together, wdata=0x1234.., addr=0x80
//    -> pmem_write only, pmem_wdata=0x1234.., pmem_read stays 0.
//  5 ch0 changes ch_address mid-BUSY from 0x100 to 0x200
//    -> pmem_address stays 0x100 until ch_resp.
//  6 rst asserted in the 2nd BUSY cycle
//    -> pmem_read falls before the next clk edge; state=IDLE, rr_ptr=0.
//    After rst release, a held request is re-granted.

Source files
------------

// File: rtl/line_arbiter_pkg.sv
// Shared types for the cache-line arbiter in front of the physical memory port.
package line_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    typedef enum logic {
        RD,
        WR
    } mem_op_t;

    // Index width for a channel count; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_arbiter_rr_picker.sv
// Combinational winner search over a request vector, starting at a given index
// and wrapping modulo NUM_CH. A start of 0 gives fixed lowest-index priority.
module rr_picker
    import line_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  start_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = IDX_W'((int'(start_i) + i) % NUM_CH);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/line_arbiter.sv
// N-channel arbiter funnelling cache-line reads/writes onto one pmem port,
// one transaction in flight, round-robin or fixed-priority grant.
module line_arbiter
    import line_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter bit RR_MODE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp
);

    localparam int IDX_W = idx_width(NUM_CH);

    arb_state_t         state_q, state_d;
    mem_op_t            op_q, op_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;

    logic [NUM_CH-1:0]  req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    assign req = ch_read | ch_write;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req_i   (req),
        .start_i (RR_MODE ? rr_ptr_q : '0),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        ch_resp      = '0;
        ch_rdata     = pmem_rdata;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = BUSY;
                    grant_d  = pick_idx;
                    addr_d   = ch_address[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d  = ch_wdata[pick_idx*LINE_W +: LINE_W];
                    // Write wins over read on the same channel: writeback before fill.
                    op_d     = ch_write[pick_idx] ? WR : RD;
                    rr_ptr_d = (int'(pick_idx) == NUM_CH - 1) ? '0 : pick_idx + 1'b1;
                end
            end
            BUSY: begin
                pmem_read  = (op_q == RD);
                pmem_write = (op_q == WR);
                if (pmem_resp) begin
                    ch_resp[grant_q] = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= RD;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_line_arbiter.sv
// Directed bench: a 2-channel round-robin arbiter and a 4-channel fixed-priority one.
module tb_line_arbiter;
    import line_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: NUM_CH=2, RR_MODE=1
    logic [1:0]   a_ch_read, a_ch_write, a_ch_resp;
    logic [63:0]  a_ch_address;
    logic [511:0] a_ch_wdata;
    logic [255:0] a_ch_rdata, a_pmem_wdata, a_pmem_rdata;
    logic         a_pmem_read, a_pmem_write, a_pmem_resp;
    logic [31:0]  a_pmem_address;

    // Instance B: NUM_CH=4, RR_MODE=0
    logic [3:0]    b_ch_read, b_ch_write, b_ch_resp;
    logic [127:0]  b_ch_address;
    logic [1023:0] b_ch_wdata;
    logic [255:0]  b_ch_rdata, b_pmem_wdata, b_pmem_rdata;
    logic          b_pmem_read, b_pmem_write, b_pmem_resp;
    logic [31:0]   b_pmem_address;

    line_arbiter #(.NUM_CH(2), .LINE_W(256), .ADDR_W(32), .RR_MODE(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .ch_read(a_ch_read), .ch_write(a_ch_write),
        .ch_address(a_ch_address), .ch_wdata(a_ch_wdata),
        .ch_rdata(a_ch_rdata), .ch_resp(a_ch_resp),
        .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata),
        .pmem_rdata(a_pmem_rdata), .pmem_resp(a_pmem_resp)
    );

    line_arbiter #(.NUM_CH(4), .LINE_W(256), .ADDR_W(32), .RR_MODE(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .ch_read(b_ch_read), .ch_write(b_ch_write),
        .ch_address(b_ch_address), .ch_wdata(b_ch_wdata),
        .ch_rdata(b_ch_rdata), .ch_resp(b_ch_resp),
        .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
        .pmem_rdata(b_pmem_rdata), .pmem_resp(b_pmem_resp)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_ch_read = '0; a_ch_write = '0; a_ch_address = '0; a_ch_wdata = '0;
        a_pmem_rdata = '0; a_pmem_resp = 1'b0;
        b_ch_read = '0; b_ch_write = '0; b_ch_address = '0; b_ch_wdata = '0;
        b_pmem_rdata = '0; b_pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({a_pmem_read, a_pmem_write, a_ch_resp, a_pmem_address} !== 36'h0) begin
            bad++;
            $display("FAIL reset_a_outputs: got rd=%b wr=%b resp=%b addr=%h want all 0",
                     a_pmem_read, a_pmem_write, a_ch_resp, a_pmem_address);
        end
        total++;
        if (a_pmem_wdata !== 256'h0) begin
            bad++; $display("FAIL reset_a_wdata: got %h want 0", a_pmem_wdata);
        end
        total++;
        if (dut_a.state_q !== IDLE || dut_a.rr_ptr_q !== 1'b0) begin
            bad++; $display("FAIL reset_a_state: got state=%0d rr=%0d want IDLE rr=0",
                            dut_a.state_q, dut_a.rr_ptr_q);
        end
        total++;
        if ({b_pmem_read, b_pmem_write, b_ch_resp} !== 6'h0) begin
            bad++; $display("FAIL reset_b_outputs: got rd=%b wr=%b resp=%b want 0",
                            b_pmem_read, b_pmem_write, b_ch_resp);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    // ch1 read at 0x1040, pmem answers in the 4th BUSY cycle.
    task automatic test_single_read();
        a_ch_read = 2'b10;
        a_ch_address[32 +: 32] = 32'h0000_1040;
        a_pmem_rdata = {32{8'hA5}};
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            a_pmem_resp = (k == 4);
            @(negedge clk);
            total++;
            if ({a_pmem_read, a_pmem_write} !== 2'b10 || a_pmem_address !== 32'h1040) begin
                bad++; $display("FAIL single_strobe cyc%0d: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=00001040",
                                k, a_pmem_read, a_pmem_write, a_pmem_address);
            end
            total++;
            if (a_ch_resp !== ((k == 4) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL single_resp cyc%0d: got %b want %b",
                                k, a_ch_resp, (k == 4) ? 2'b10 : 2'b00);
            end
        end
        total++;
        if (a_ch_rdata !== {32{8'hA5}}) begin
            bad++; $display("FAIL single_rdata: got %h want a5..a5", a_ch_rdata);
        end
        next_cycle();
        a_pmem_resp = 1'b0;
        a_ch_read = 2'b00;
        @(negedge clk);
        total++;
        if (dut_a.state_q !== DONE || {a_pmem_read, a_pmem_write, a_ch_resp} !== 4'b0) begin
            bad++; $display("FAIL single_done: got state=%0d rd=%b wr=%b resp=%b want DONE and quiet",
                            dut_a.state_q, a_pmem_read, a_pmem_write, a_ch_resp);
        end
        total++;
        if (dut_a.rr_ptr_q !== 1'b0) begin
            bad++; $display("FAIL single_rr_wrap: got %0d want 0", dut_a.rr_ptr_q);
        end
        next_cycle();
    endtask

    task automatic test_rr_collision();
        logic [1:0] exp_resp [4];
        exp_resp = '{2'b01, 2'b10, 2'b01, 2'b10};
        a_ch_read = 2'b11;
        a_ch_address[0 +: 32] = 32'h0000_2000;
        a_ch_address[32 +: 32] = 32'h0000_3000;
        for (int t = 0; t < 4; t++) begin
            next_cycle();
            a_pmem_resp = 1'b1;
            @(negedge clk);
            total++;
            if (a_ch_resp !== exp_resp[t] || a_pmem_read !== 1'b1 ||
                a_pmem_address !== (exp_resp[t][0] ? 32'h2000 : 32'h3000)) begin
                bad++; $display("FAIL rr_grant txn%0d: got resp=%b rd=%b addr=%h want resp=%b rd=1",
                                t, a_ch_resp, a_pmem_read, a_pmem_address, exp_resp[t]);
            end
            next_cycle();
            a_pmem_resp = 1'b0;
            @(negedge clk);
            total++;
            if ({a_ch_resp, a_pmem_read} !== 3'b000) begin
                bad++; $display("FAIL rr_done txn%0d: got resp=%b rd=%b want 0",
                                t, a_ch_resp, a_pmem_read);
            end
            next_cycle();
        end
        a_ch_read = 2'b00;
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        b_ch_read = 4'b1010;
        b_pmem_resp = 1'b1;
        for (int t = 0; t < 3; t++) begin
            next_cycle();
            @(negedge clk);
            total++;
            if ({b_pmem_read, b_ch_resp} !== 5'b1_0010) begin
                bad++; $display("FAIL fixed_grant txn%0d: got rd=%b resp=%b want rd=1 resp=0010",
                                t, b_pmem_read, b_ch_resp);
            end
            next_cycle();
            next_cycle();
        end
        b_ch_read = 4'b1000;
        next_cycle();
        @(negedge clk);
        total++;
        if (b_ch_resp !== 4'b1000) begin
            bad++; $display("FAIL fixed_ch3_after_drop: got %b want 1000", b_ch_resp);
        end
        next_cycle();
        b_ch_read = 4'b0000;
        b_pmem_resp = 1'b0;
        next_cycle();
    endtask

    task automatic test_write_wins();
        a_ch_read = 2'b01;
        a_ch_write = 2'b01;
        a_ch_address[0 +: 32] = 32'h0000_0080;
        a_ch_wdata[0 +: 256] = {8{32'h1234_5678}};
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            a_pmem_resp = (k == 2);
            @(negedge clk);
            total++;
            if ({a_pmem_read, a_pmem_write} !== 2'b01 || a_pmem_address !== 32'h80 ||
                a_pmem_wdata !== {8{32'h1234_5678}}) begin
                bad++; $display("FAIL write_wins cyc%0d: got rd=%b wr=%b addr=%h wdata=%h want rd=0 wr=1 addr=00000080",
                                k, a_pmem_read, a_pmem_write, a_pmem_address, a_pmem_wdata);
            end
        end
        total++;
        if (a_ch_resp !== 2'b01) begin
            bad++; $display("FAIL write_resp: got %b want 01", a_ch_resp);
        end
        next_cycle();
        a_pmem_resp = 1'b0;
        a_ch_read = 2'b00;
        a_ch_write = 2'b00;
        next_cycle();
    endtask

    task automatic test_addr_stable();
        a_ch_read = 2'b01;
        a_ch_address[0 +: 32] = 32'h0000_0100;
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 2) a_ch_address[0 +: 32] = 32'h0000_0200;
            a_pmem_resp = (k == 3);
            @(negedge clk);
            total++;
            if (a_pmem_address !== 32'h100 || a_ch_resp !== ((k == 3) ? 2'b01 : 2'b00)) begin
                bad++; $display("FAIL addr_stable cyc%0d: got addr=%h resp=%b want addr=00000100 resp=%b",
                                k, a_pmem_address, a_ch_resp, (k == 3) ? 2'b01 : 2'b00);
            end
        end
        next_cycle();
        a_pmem_resp = 1'b0;
        a_ch_read = 2'b00;
        next_cycle();
    endtask

    task automatic test_drop_mid_busy();
        a_ch_read = 2'b10;
        a_ch_address[32 +: 32] = 32'h0000_4440;
        next_cycle();
        a_ch_read = 2'b00;
        next_cycle();
        a_pmem_resp = 1'b1;
        @(negedge clk);
        total++;
        if (a_ch_resp !== 2'b10 || a_pmem_address !== 32'h4440) begin
            bad++; $display("FAIL drop_mid_busy: got resp=%b addr=%h want resp=10 addr=00004440",
                            a_ch_resp, a_pmem_address);
        end
        next_cycle();
        a_pmem_resp = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_busy();
        a_ch_read = 2'b01;
        a_ch_address[0 +: 32] = 32'h0000_0300;
        next_cycle();
        @(negedge clk);
        total++;
        if (a_pmem_read !== 1'b1 || dut_a.rr_ptr_q !== 1'b1) begin
            bad++; $display("FAIL rst_pre busy: got rd=%b rr=%0d want rd=1 rr=1",
                            a_pmem_read, dut_a.rr_ptr_q);
        end
        next_cycle();
        rst = 1'b1;
        #1;
        total++;
        if (a_pmem_read !== 1'b0 || dut_a.state_q !== IDLE || dut_a.rr_ptr_q !== 1'b0 ||
            dut_a.grant_q !== 1'b0 || a_ch_resp !== 2'b00) begin
            bad++; $display("FAIL rst_async: got rd=%b state=%0d rr=%0d grant=%0d resp=%b want 0 IDLE 0 0 00",
                            a_pmem_read, dut_a.state_q, dut_a.rr_ptr_q, dut_a.grant_q, a_ch_resp);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        a_pmem_resp = 1'b1;
        @(negedge clk);
        total++;
        if (a_pmem_read !== 1'b1 || a_pmem_address !== 32'h300 || a_ch_resp !== 2'b01) begin
            bad++; $display("FAIL rst_regrant: got rd=%b addr=%h resp=%b want rd=1 addr=00000300 resp=01",
                            a_pmem_read, a_pmem_address, a_ch_resp);
        end
        next_cycle();
        a_pmem_resp = 1'b0;
        a_ch_read = 2'b00;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_collision();
        test_fixed_priority();
        test_write_wins();
        test_addr_stable();
        test_drop_mid_busy();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
